hazard_scoreboard: RTL

Parametrised hazard and forwarding controller for the MIPS pipeline. It sits between decode/issue and the execute stage. It tracks every in-flight register write in a shift-register scoreboard and asserts a stall on load-use and other not-yet-ready dependencies. It also produces registered forwarding selects for the instruction entering EX, for any pipeline depth and result latency.

---
 rtl/hazard_scoreboard.sv | 119 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard: shift-register record of in-flight register writes, combinational issue stall, registered EX forwarding selects.
// Optional statistics counters are enabled by defining HAZARD_SB_STATS_EN.
module hazard_scoreboard #(
  parameter int DEPTH      = 3,
  parameter int REG_AW     = 5,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  localparam int SELW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rs,
  input  logic [REG_AW-1:0] issue_rt,
  input  logic              issue_use_rs,
  input  logic              issue_use_rt,
  input  logic [REG_AW-1:0] issue_dst,
  input  logic              issue_wen,
  input  logic              issue_load,
  input  logic              flush,
  output logic              stall,
  output logic [SELW-1:0]   fwd_sel_rs,
  output logic [SELW-1:0]   fwd_sel_rt,
  output logic              sb_busy
`ifdef HAZARD_SB_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       fwd_cnt
`endif
);

  typedef struct packed {
    logic            hz;
    logic [SELW-1:0] sel;
  } look_t;

  logic [DEPTH-1:0]             v_q, v_next;
  logic [DEPTH-1:0]             ld_q, ld_next;
  logic [DEPTH-1:0][REG_AW-1:0] dst_q, dst_next;
  look_t                        lk_rs, lk_rt;
  logic                         accept;
  logic                         alloc;

  // Youngest valid match wins; the consumer sees it one position older when it reaches EX.
  function automatic look_t lookup(input logic use_src, input logic [REG_AW-1:0] src,
                                   input logic [DEPTH-1:0] v, input logic [DEPTH-1:0] ld,
                                   input logic [DEPTH-1:0][REG_AW-1:0] dst);
    look_t r;
    logic  hit;
    logic  hit_ld;
    int    pos;
    int    need;
    r      = '0;
    hit    = 1'b0;
    hit_ld = 1'b0;
    pos    = 0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v[i] && dst[i] == src) begin
        hit    = 1'b1;
        hit_ld = ld[i];
        pos    = i;
      end
    end
    if (use_src && src != '0 && hit) begin
      need = hit_ld ? LOAD_READY : ALU_READY;
      if (pos + 1 < need) r.hz = 1'b1;
      else if (pos + 1 < DEPTH) r.sel = SELW'(pos + 1);
    end
    return r;
  endfunction

  always_comb begin
    lk_rs  = lookup(issue_use_rs, issue_rs, v_q, ld_q, dst_q);
    lk_rt  = lookup(issue_use_rt, issue_rt, v_q, ld_q, dst_q);
    stall  = issue_valid & ~flush & (lk_rs.hz | lk_rt.hz);
    accept = issue_valid & ~flush & ~stall;
    alloc  = accept & issue_wen & (issue_dst != '0);
  end

  // Older entries always advance; flush only kills what was sitting in P[0].
  always_comb begin
    v_next   = {v_q[DEPTH-2:0], alloc};
    ld_next  = {ld_q[DEPTH-2:0], issue_load};
    dst_next = {dst_q[DEPTH-2:0], issue_dst};
    if (flush) v_next[1] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q        <= '0;
      ld_q       <= '0;
      dst_q      <= '0;
      fwd_sel_rs <= '0;
      fwd_sel_rt <= '0;
      sb_busy    <= 1'b0;
    end else begin
      v_q        <= v_next;
      ld_q       <= ld_next;
      dst_q      <= dst_next;
      fwd_sel_rs <= accept ? lk_rs.sel : '0;
      fwd_sel_rt <= accept ? lk_rt.sel : '0;
      sb_busy    <= |v_next;
    end
  end

`ifdef HAZARD_SB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (accept && (lk_rs.sel != '0 || lk_rt.sel != '0) && fwd_cnt != 16'hFFFF)
        fwd_cnt <= fwd_cnt + 16'd1;
    end
  end
`endif

endmodule
